branch_predict_ctrl: RTL and testbench

- Scheduler and bookkeeper for 2-bit saturating branch prediction in the pipelined core.
- Holds a PC-indexed pattern history table (PHT) of 2-bit counters and answers fetch-stage prediction queries.
- Tracks in-flight predictions in a FIFO, matches them in order against execute-stage resolutions, updates the PHT, and raises mispredict/flush.
- Keeps saturating performance counters.

---
 rtl/bpc_pkg.sv | 32 +++
 rtl/bpc_inflight_fifo.sv | 56 +++++
 rtl/branch_predict_ctrl.sv | 97 +++++++++
 tb/tb_branch_predict_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/bpc_pkg.sv
// Shared types and helpers for the 2-bit saturating branch predictor.
// Purely declarative: no state, no latency, no flow control.
// Counter encoding: 0 strongly taken .. 3 strongly not taken.
package bpc_pkg;

  localparam int BPC_IDX_W_MAX = 16;

  typedef logic [1:0] bp_cnt_t;

  localparam bp_cnt_t BP_ST = 2'd0;
  localparam bp_cnt_t BP_WT = 2'd1;
  localparam bp_cnt_t BP_WN = 2'd2;
  localparam bp_cnt_t BP_SN = 2'd3;

  // idx is sized for the widest supported table; narrower tables zero-extend.
  typedef struct packed {
    logic [BPC_IDX_W_MAX-1:0] idx;
    logic                     pred;
  } bpc_entry_t;

  function automatic bp_cnt_t bp_next(input bp_cnt_t cur, input logic taken);
    bp_cnt_t nxt;
    if (taken) nxt = (cur == BP_ST) ? BP_ST : cur - 2'd1;
    else       nxt = (cur == BP_SN) ? BP_SN : cur + 2'd1;
    return nxt;
  endfunction

  function automatic logic bp_taken(input bp_cnt_t cur);
    return (cur == BP_ST) || (cur == BP_WT);
  endfunction

endpackage

// File: rtl/bpc_inflight_fifo.sv
// In-flight prediction FIFO with synchronous clear.
// Latency: a push is visible at the head one cycle later; head read is combinational.
// Backpressure: full is reported to the caller; pushes while full or during clear are dropped.
module bpc_inflight_fifo
  import bpc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic       clear,
  input  bpc_entry_t wr_dat,
  output bpc_entry_t rd_dat,
  output logic       full,
  output logic       empty
);

  localparam int PW = $clog2(DEPTH);

  bpc_entry_t      mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     cnt;
  logic            push_vld;
  logic            pop_vld;

  assign full     = (cnt == (PW+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign push_vld = push && !full && !clear;
  assign pop_vld  = pop && !empty;
  assign rd_dat   = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + 1'b1;
      if (pop_vld)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (PW+1)'(push_vld) - (PW+1)'(pop_vld);
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// 2-bit PHT branch predictor: fetch query, in-order resolve, flush on mispredict. BPC_GSHARE_EN adds gshare GHR.
// Latency: prediction is combinational; PHT, counters and FIFO update on the resolving edge.
// Backpressure: if_stall holds fetch while the in-flight FIFO is full; a same-cycle pop does not release it.
module branch_predict_ctrl
  import bpc_pkg::*;
#(
  parameter int PHT_IDX_W  = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  input  logic             if_is_branch,
  input  logic [31:0]      if_pc,
  output logic             if_predict_taken,
  output logic             if_stall,
  input  logic             ex_resolve_valid,
  input  logic             ex_is_taken,
  output logic             ex_mispredict,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count,
  output logic             resolve_err
);

  localparam int PHT_N = 1 << PHT_IDX_W;

  bp_cnt_t              pht [PHT_N];
  logic [PHT_IDX_W-1:0] fetch_idx;
  logic [PHT_IDX_W-1:0] head_idx;
  bpc_entry_t           push_ent;
  bpc_entry_t           head;
  logic                 fifo_empty;
  logic                 push_vld;
  logic                 pop_vld;
  logic                 unused_bits;

`ifdef BPC_GSHARE_EN
  logic [PHT_IDX_W-1:0] ghr;

  assign fetch_idx = if_pc[PHT_IDX_W+1:2] ^ ghr;

  // History only advances on resolved branches, so no speculative repair is needed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       ghr <= '0;
    else if (pop_vld) ghr <= {ghr[PHT_IDX_W-2:0], ex_is_taken};
  end
`else
  assign fetch_idx = if_pc[PHT_IDX_W+1:2];
`endif

  assign head_idx         = head.idx[PHT_IDX_W-1:0];
  assign unused_bits      = ^{if_pc[31:PHT_IDX_W+2], if_pc[1:0], head.idx >> PHT_IDX_W};
  assign if_predict_taken = bp_taken(pht[fetch_idx]);
  assign pop_vld          = ex_resolve_valid && !fifo_empty;
  assign ex_mispredict    = pop_vld && (head.pred != ex_is_taken);
  assign push_vld         = if_valid && if_is_branch && !if_stall && !ex_mispredict;
  assign push_ent         = '{idx: BPC_IDX_W_MAX'(fetch_idx), pred: if_predict_taken};

  bpc_inflight_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push_vld),
    .pop    (pop_vld),
    .clear  (ex_mispredict),
    .wr_dat (push_ent),
    .rd_dat (head),
    .full   (if_stall),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PHT_N; i++) pht[i] <= BP_ST;
    end else if (pop_vld) begin
      pht[head_idx] <= bp_next(pht[head_idx], ex_is_taken);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
      resolve_err      <= 1'b0;
    end else begin
      if (pop_vld && branch_count != '1)
        branch_count <= branch_count + 1'b1;
      if (ex_mispredict && mispredict_count != '1)
        mispredict_count <= mispredict_count + 1'b1;
      if (ex_resolve_valid && fifo_empty)
        resolve_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed + randomized bench for branch_predict_ctrl against a queue/array reference model.
module tb_branch_predict_ctrl;

  localparam int IW    = 5;
  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_valid, if_is_branch;
  logic [31:0]   if_pc;
  logic          if_predict_taken, if_stall;
  logic          ex_resolve_valid, ex_is_taken, ex_mispredict;
  logic [CW-1:0] branch_count, mispredict_count;
  logic          resolve_err;

  always #5 clk = ~clk;

  branch_predict_ctrl #(.PHT_IDX_W(IW), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk              (clk),
    .reset            (reset),
    .if_valid         (if_valid),
    .if_is_branch     (if_is_branch),
    .if_pc            (if_pc),
    .if_predict_taken (if_predict_taken),
    .if_stall         (if_stall),
    .ex_resolve_valid (ex_resolve_valid),
    .ex_is_taken      (ex_is_taken),
    .ex_mispredict    (ex_mispredict),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count),
    .resolve_err      (resolve_err)
  );

  typedef struct {
    int idx;
    bit pred;
  } ent_t;

  int   n_cmp = 0;
  int   n_err = 0;
  int   m_pht [1 << IW];
  ent_t m_q [$];
  int   m_bc, m_mc, m_ghr;
  bit   m_err;

  function automatic void m_reset();
    foreach (m_pht[i]) m_pht[i] = 0;
    m_q.delete();
    m_bc = 0; m_mc = 0; m_ghr = 0; m_err = 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, compare outputs mid-cycle, then advance the model past the rising edge.
  task automatic step(input bit rst_n, input bit v, input bit br, input logic [31:0] pc,
                      input bit rv, input bit tk);
    int   idx;
    bit   e_pred, e_stall, e_mp, push;
    ent_t h;
    @(negedge clk);
    reset = rst_n; if_valid = v; if_is_branch = br; if_pc = pc;
    ex_resolve_valid = rv; ex_is_taken = tk;
    if (!rst_n) m_reset();
    idx     = ((pc >> 2) % (1 << IW)) ^ m_ghr;
    e_pred  = (m_pht[idx] < 2);
    e_stall = (m_q.size() == DEPTH);
    e_mp    = rst_n && rv && (m_q.size() > 0) && (m_q[0].pred != tk);
    #1;
    chk("predict",          if_predict_taken, e_pred);
    chk("stall",            if_stall,         e_stall);
    chk("mispredict",       ex_mispredict,    e_mp);
    chk("branch_count",     branch_count,     m_bc);
    chk("mispredict_count", mispredict_count, m_mc);
    chk("resolve_err",      resolve_err,      m_err);
    if (rst_n) begin
      push = v && br && !e_stall && !e_mp;
      if (rv && m_q.size() == 0) m_err = 1;
      if (rv && m_q.size() > 0) begin
        h = m_q.pop_front();
        m_pht[h.idx] = tk ? ((m_pht[h.idx] > 0) ? m_pht[h.idx] - 1 : 0)
                          : ((m_pht[h.idx] < 3) ? m_pht[h.idx] + 1 : 3);
        if (m_bc < CMAX) m_bc++;
        if (e_mp && m_mc < CMAX) m_mc++;
`ifdef BPC_GSHARE_EN
        m_ghr = ((m_ghr << 1) | int'(tk)) % (1 << IW);
`endif
      end
      if (e_mp) m_q.delete();
      else if (push) m_q.push_back('{idx: idx, pred: e_pred});
    end
  endtask

  int bc_before;

  initial begin
    reset = 1'b0; if_valid = 0; if_is_branch = 0; if_pc = '0;
    ex_resolve_valid = 0; ex_is_taken = 0;
    m_reset();

    // Reset state, with a resolve attempted during reset
    step(0, 1, 1, 32'h100, 1, 0);
    chk("rst_predict", if_predict_taken, 1);
    chk("rst_stall",   if_stall, 0);
    chk("rst_mp",      ex_mispredict, 0);
    step(1, 1, 0, 32'h100, 0, 0);
    chk("query_0x100", if_predict_taken, 1);

    // Two pushes, first resolve not-taken flushes the second
    step(1, 1, 1, 32'h100, 0, 0);
    step(1, 1, 1, 32'h100, 0, 0);
    step(1, 0, 0, 32'h0,   1, 0);
    chk("flush_mp", ex_mispredict, 1);
    step(1, 1, 1, 32'h100, 0, 0);
    chk("pred_wt", if_predict_taken, 1);
    step(1, 0, 0, 32'h100, 1, 0);
    chk("wt_mp", ex_mispredict, 1);
    step(1, 1, 0, 32'h100, 0, 0);
    chk("pred_wn", if_predict_taken, 0);

    // Fill to full, hold the 5th, pop does not release stall this cycle
    for (int i = 1; i <= DEPTH; i++) step(1, 1, 1, 32'h100 + 4 * i, 0, 0);
    step(1, 1, 1, 32'h114, 0, 0);
    chk("full_stall", if_stall, 1);
    step(1, 1, 1, 32'h114, 1, 1);
    chk("pop_still_stall", if_stall, 1);
    chk("pop_no_mp", ex_mispredict, 0);
    step(1, 1, 1, 32'h114, 0, 0);
    chk("stall_release", if_stall, 0);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 32'h0, 1, 1);

    // Resolve on empty FIFO
    bc_before = m_bc;
    step(1, 0, 0, 32'h0, 1, 0);
    step(1, 0, 0, 32'h0, 0, 0);
    chk("err_set", resolve_err, 1);
    chk("err_bc",  branch_count, bc_before);

    // Simultaneous push and correct resolve
    step(1, 1, 1, 32'h200, 0, 0);
    step(1, 1, 1, 32'h200, 1, m_q[0].pred);
    chk("simul_no_mp", ex_mispredict, 0);
    step(1, 0, 0, 32'h200, 0, 0);

    // Randomized traffic with occasional mid-operation reset
    for (int n = 0; n < 800; n++) begin
      logic [31:0] pc;
      pc = ($urandom & 32'hFFFF_FF83) | ($urandom_range(0, 3) << 2);
      step(($urandom_range(0, 63) != 0), $urandom_range(0, 1), ($urandom_range(0, 3) != 0),
           pc, $urandom_range(0, 1), $urandom_range(0, 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
